// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ctrl_pkg
// Description : Shared types for the multi-cycle RV32I control unit. Holds the
//               FSM state encoding, the RV32I major opcodes, the instruction
//               class recorded in DECODE, the trap cause encoding, and an
//               opcode classifier.
// Revision    : 1.0  initial release
// ============================================================================
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_JUMP    = 3'd4,
        CLS_ILLEGAL = 3'd5
    } instr_class_t;

    typedef enum logic [1:0] {
        TC_NONE         = 2'd0,
        TC_ILLEGAL      = 2'd1,
        TC_IMEM_TIMEOUT = 2'd2,
        TC_DMEM_TIMEOUT = 2'd3
    } trap_cause_t;

    // Maps a major opcode onto the class that steers EXECUTE/MEMORY/WRITEBACK.
    function automatic instr_class_t classify(input logic [6:0] opc);
        instr_class_t cls;
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: cls = CLS_ALU;
            OPC_LOAD:                               cls = CLS_LOAD;
            OPC_STORE:                              cls = CLS_STORE;
            OPC_BRANCH:                             cls = CLS_BRANCH;
            OPC_JAL, OPC_JALR:                      cls = CLS_JUMP;
            default:                                cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_timer
// Description : Counts consecutive memory wait cycles. expired is high while
//               the count equals MEM_TIMEOUT; the count saturates there.
// Ports       : clk, rst (sync, active-high), clear (zero the count),
//               tick (one more wait cycle), expired (limit reached)
// Revision    : 1.0  initial release
// ============================================================================
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    logic [TW-1:0] r_count;

    assign expired = (r_count == TW'(MEM_TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (tick && !expired) begin
            r_count <= r_count + TW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_fsm
// Description : Multi-cycle RV32I control unit sequencing FETCH, DECODE,
//               EXECUTE, MEMORY and WRITEBACK, with a sticky TRAP state for
//               illegal opcodes and memory handshake timeouts.
// Ports       : clk, rst (sync, active-high); instruction[31:0] (IR),
//               imem_ready, dmem_ready, branch_taken;
//               imem_req, ir_load, immgen_en_d, pc_write, dmem_req, dmem_we,
//               reg_write, instr_retired, trap, trap_cause[1:0].
// Config      : CTRL_PERF_CNT_EN adds cycle_cnt[31:0] and retired_cnt[31:0].
// Revision    : 1.0  initial release
// ============================================================================
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        branch_taken,
    output logic        imem_req,
    output logic        ir_load,
    output logic        immgen_en_d,
    output logic        pc_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        reg_write,
    output logic        instr_retired,
    output logic        trap,
`ifdef CTRL_PERF_CNT_EN
    output logic [31:0] cycle_cnt,
    output logic [31:0] retired_cnt,
`endif
    output logic [1:0]  trap_cause
);

    state_t       r_state;
    state_t       w_next;
    instr_class_t r_class;
    trap_cause_t  r_cause;
    trap_cause_t  w_cause_next;
    logic         w_tick;
    logic         w_expired;

    // Only the opcode steers control; branch_taken only selects the PC source
    // inside the datapath, pc_write is asserted either way.
    logic w_unused_inputs;
    assign w_unused_inputs = ^{instruction[31:7], branch_taken};

    // Any cycle that is not a stalled memory cycle restarts the count, so the
    // timer is always zero on entry to FETCH or MEMORY.
    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!w_tick),
        .tick    (w_tick),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_class <= CLS_ALU;
            r_cause <= TC_NONE;
        end else begin
            r_state <= w_next;
            r_cause <= w_cause_next;
            if (r_state == ST_DECODE) begin
                r_class <= classify(instruction[6:0]);
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        w_cause_next  = r_cause;
        w_tick        = 1'b0;
        imem_req      = 1'b0;
        ir_load       = 1'b0;
        immgen_en_d   = 1'b0;
        pc_write      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        reg_write     = 1'b0;
        instr_retired = 1'b0;
        trap          = 1'b0;
        trap_cause    = r_cause;

        case (r_state)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load = 1'b1;
                    w_next  = ST_DECODE;
                end else begin
                    w_tick = 1'b1;
                    if (w_expired) begin
                        w_next       = ST_TRAP;
                        w_cause_next = TC_IMEM_TIMEOUT;
                    end
                end
            end
            ST_DECODE: begin
                immgen_en_d = 1'b1;
                if (classify(instruction[6:0]) == CLS_ILLEGAL) begin
                    w_next       = ST_TRAP;
                    w_cause_next = TC_ILLEGAL;
                end else begin
                    w_next = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                immgen_en_d = 1'b1;
                case (r_class)
                    CLS_BRANCH: begin
                        pc_write      = 1'b1;
                        instr_retired = 1'b1;
                        w_next        = ST_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: w_next = ST_MEMORY;
                    default:             w_next = ST_WRITEBACK;
                endcase
            end
            ST_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = (r_class == CLS_STORE);
                if (dmem_ready) begin
                    if (r_class == CLS_STORE) begin
                        pc_write      = 1'b1;
                        instr_retired = 1'b1;
                        w_next        = ST_FETCH;
                    end else begin
                        w_next = ST_WRITEBACK;
                    end
                end else begin
                    w_tick = 1'b1;
                    if (w_expired) begin
                        w_next       = ST_TRAP;
                        w_cause_next = TC_DMEM_TIMEOUT;
                    end
                end
            end
            ST_WRITEBACK: begin
                reg_write     = 1'b1;
                pc_write      = 1'b1;
                instr_retired = 1'b1;
                w_next        = ST_FETCH;
            end
            ST_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                w_next = ST_FETCH;
            end
        endcase

        // Reset overrides whatever state the register still holds this cycle.
        if (rst) begin
            imem_req      = 1'b0;
            ir_load       = 1'b0;
            immgen_en_d   = 1'b0;
            pc_write      = 1'b0;
            dmem_req      = 1'b0;
            dmem_we       = 1'b0;
            reg_write     = 1'b0;
            instr_retired = 1'b0;
            trap          = 1'b0;
            trap_cause    = 2'd0;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_retired_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt   <= '0;
            r_retired_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (instr_retired) begin
                r_retired_cnt <= r_retired_cnt + 32'd1;
            end
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign retired_cnt = r_retired_cnt;
`else
    // Performance counters not built.
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl_fsm
// Description : Self-checking bench for multicycle_ctrl_fsm. A table of
//               instructions with memory wait profiles and expected per-
//               instruction activity counts, plus hand-written sequences for
//               the cycle trace, trap stickiness and reset mid-MEMORY.
// Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl_fsm;

    localparam int MEM_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction = 32'h0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic        imem_req, ir_load, immgen_en_d, pc_write;
    logic        dmem_req, dmem_we, reg_write, instr_retired, trap;
    logic [1:0]  trap_cause;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, retired_cnt;
`endif

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .instruction   (instruction),
        .imem_ready    (imem_ready),
        .dmem_ready    (dmem_ready),
        .branch_taken  (branch_taken),
        .imem_req      (imem_req),
        .ir_load       (ir_load),
        .immgen_en_d   (immgen_en_d),
        .pc_write      (pc_write),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .reg_write     (reg_write),
        .instr_retired (instr_retired),
        .trap          (trap),
`ifdef CTRL_PERF_CNT_EN
        .cycle_cnt     (cycle_cnt),
        .retired_cnt   (retired_cnt),
`endif
        .trap_cause    (trap_cause)
    );

    always #5 clk = ~clk;

    logic [10:0] outs;
    assign outs = {imem_req, ir_load, immgen_en_d, pc_write, dmem_req, dmem_we,
                   reg_write, instr_retired, trap, trap_cause};

    typedef struct {
        logic [31:0] instr;
        int iw, dw;
        bit bt;
        int cyc, ir, imm, dreq, we, rw, pcw, ret, trp, cause;
    } vec_t;

    vec_t table_q[$];
    vec_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] instr, input int iw, input int dw, input bit bt,
                       input int cyc, input int ir, input int imm, input int dreq, input int we,
                       input int rw, input int pcw, input int ret, input int trp, input int cause);
        vec_t v;
        v.instr = instr; v.iw = iw; v.dw = dw; v.bt = bt;
        v.cyc = cyc; v.ir = ir; v.imm = imm; v.dreq = dreq; v.we = we;
        v.rw = rw; v.pcw = pcw; v.ret = ret; v.trp = trp; v.cause = cause;
        table_q.push_back(v);
    endtask

    // Entered at a negedge; leaves the bench part-way into the first
    // post-reset cycle with that cycle's inputs not yet chosen.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #1;
        check({tag, ".rst_outs"}, int'(outs), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check({tag, ".post_rst_fetch"}, {imem_req, dmem_req, immgen_en_d}, 3'b100);
        check({tag, ".post_rst_trap"}, {trap, trap_cause}, 0);
`ifdef CTRL_PERF_CNT_EN
        check({tag, ".cycle_cnt"}, int'(cycle_cnt), 0);
        check({tag, ".retired_cnt"}, int'(retired_cnt), 0);
`endif
    endtask

    // Runs one instruction from its first FETCH cycle to retirement or trap.
    task automatic run_vec(input int idx, input vec_t v);
        vec_t o, e;
        int   iw, dw;
        bit   done;
        string nm;
        o = v;
        o.cyc = 0; o.ir = 0; o.imm = 0; o.dreq = 0; o.we = 0;
        o.rw = 0; o.pcw = 0; o.ret = 0; o.trp = 0; o.cause = 0;
        iw = v.iw; dw = v.dw; done = 1'b0;
        instruction  = v.instr;
        branch_taken = v.bt;
        exp_q.push_back(v);
        while (!done && o.cyc < 100) begin
            if (trap) begin
                o.trp   = 1;
                o.cause = int'(trap_cause);
                done    = 1'b1;
            end else begin
                if (imem_req) begin
                    if (iw == 0) imem_ready = 1'b1;
                    else begin imem_ready = 1'b0; iw--; end
                end else begin
                    imem_ready = 1'($urandom_range(0, 1));
                end
                if (dmem_req) begin
                    if (dw == 0) dmem_ready = 1'b1;
                    else begin dmem_ready = 1'b0; dw--; end
                end else begin
                    dmem_ready = 1'($urandom_range(0, 1));
                end
                #1;
                o.cyc++;
                o.ir   += int'(ir_load);
                o.imm  += int'(immgen_en_d);
                o.dreq += int'(dmem_req);
                o.we   += int'(dmem_we);
                o.rw   += int'(reg_write);
                o.pcw  += int'(pc_write);
                o.ret  += int'(instr_retired);
                if (instr_retired) done = 1'b1;
                @(negedge clk);
            end
        end
        nm = $sformatf("v%0d", idx);
        check({nm, ".completed"}, int'(done), 1);
        e = exp_q.pop_front();
        check({nm, ".cycles"},        o.cyc,   e.cyc);
        check({nm, ".ir_load"},       o.ir,    e.ir);
        check({nm, ".immgen_en_d"},   o.imm,   e.imm);
        check({nm, ".dmem_req"},      o.dreq,  e.dreq);
        check({nm, ".dmem_we"},       o.we,    e.we);
        check({nm, ".reg_write"},     o.rw,    e.rw);
        check({nm, ".pc_write"},      o.pcw,   e.pcw);
        check({nm, ".instr_retired"}, o.ret,   e.ret);
        check({nm, ".trap"},          o.trp,   e.trp);
        check({nm, ".trap_cause"},    o.cause, e.cause);
    endtask

    initial begin
        logic [3:0] t_req, t_irl, t_imm, t_rw, t_ret;

        //   instr         iw dw bt  cyc ir imm dreq we rw pcw ret trp cause
        add(32'h00500093,  0, 0, 0,   4, 1, 2,  0,  0, 1, 1,  1,  0, 0); // ADDI
        add(32'h0000A103,  0, 3, 0,   8, 1, 2,  4,  0, 1, 1,  1,  0, 0); // LW, 3 waits
        add(32'h00112023,  0, 0, 0,   4, 1, 2,  1,  1, 0, 1,  1,  0, 0); // SW
        add(32'h00000063,  0, 0, 1,   3, 1, 2,  0,  0, 0, 1,  1,  0, 0); // BEQ taken
        add(32'h00000063,  0, 0, 0,   3, 1, 2,  0,  0, 0, 1,  1,  0, 0); // BEQ not taken
        add(32'h123450B7,  2, 0, 0,   6, 1, 2,  0,  0, 1, 1,  1,  0, 0); // LUI, 2 imem waits
        add(32'h00000097,  0, 0, 0,   4, 1, 2,  0,  0, 1, 1,  1,  0, 0); // AUIPC
        add(32'h0000006F,  0, 0, 0,   4, 1, 2,  0,  0, 1, 1,  1,  0, 0); // JAL
        add(32'h00008067,  0, 0, 0,   4, 1, 2,  0,  0, 1, 1,  1,  0, 0); // JALR
        add(32'h002081B3,  0, 0, 0,   4, 1, 2,  0,  0, 1, 1,  1,  0, 0); // ADD
        add(32'h00112023,  0, 2, 0,   6, 1, 2,  3,  3, 0, 1,  1,  0, 0); // SW, 2 waits
        add(32'h0000A103,  1, 0, 0,   6, 1, 2,  1,  0, 1, 1,  1,  0, 0); // LW, 1 imem wait
        add(32'h0000007F,  0, 0, 0,   2, 1, 1,  0,  0, 0, 0,  0,  1, 1); // illegal opcode
        add(32'h00500093, 16, 0, 0,  20, 1, 2,  0,  0, 1, 1,  1,  0, 0); // ready on limit cycle
        add(32'h00500093, 17, 0, 0,  17, 0, 0,  0,  0, 0, 0,  0,  1, 2); // imem timeout
        add(32'h0000A103,  0,16, 0,  21, 1, 2, 17,  0, 1, 1,  1,  0, 0); // dmem ready on limit
        add(32'h0000A103,  0,17, 0,  20, 1, 2, 17,  0, 0, 0,  0,  1, 3); // dmem timeout (load)
        add(32'h00112023,  0,17, 0,  20, 1, 2, 17, 17, 0, 0,  0,  1, 3); // dmem timeout (store)

        @(negedge clk);
        do_reset("init");

        // Cycle-by-cycle trace of ADDI with zero-wait memory.
        instruction = 32'h00500093;
        imem_ready  = 1'b1;
        dmem_ready  = 1'b0;
        t_req = '0; t_irl = '0; t_imm = '0; t_rw = '0; t_ret = '0;
        for (int c = 0; c < 4; c++) begin
            #1;
            t_req[c] = imem_req;
            t_irl[c] = ir_load;
            t_imm[c] = immgen_en_d;
            t_rw[c]  = reg_write;
            t_ret[c] = instr_retired;
            @(negedge clk);
        end
        check("trace.imem_req",      int'(t_req), 4'b0001);
        check("trace.ir_load",       int'(t_irl), 4'b0001);
        check("trace.immgen_en_d",   int'(t_imm), 4'b0110);
        check("trace.reg_write",     int'(t_rw),  4'b1000);
        check("trace.instr_retired", int'(t_ret), 4'b1000);

        for (int i = 0; i < table_q.size(); i++) begin
            run_vec(i, table_q[i]);
            if (table_q[i].trp != 0) begin
                // Trap must hold with all enables low whatever the inputs do.
                for (int k = 0; k < 4; k++) begin
                    imem_ready = 1'($urandom_range(0, 1));
                    dmem_ready = 1'($urandom_range(0, 1));
                    #1;
                    check($sformatf("v%0d.sticky%0d", i, k), int'(outs),
                          {9'b000000001, 2'(table_q[i].cause)});
                    @(negedge clk);
                end
                do_reset($sformatf("v%0d", i));
            end
        end

        // Reset while a load is stalled in MEMORY.
        instruction = 32'h0000A103;
        begin
            bit seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                imem_ready = 1'b1;
                dmem_ready = 1'b0;
                #1;
                if (dmem_req) seen = 1'b1;
                @(negedge clk);
            end
            check("midmem.reached", int'(seen), 1);
        end
        dmem_ready = 1'b0;
        #1;
        check("midmem.still_waiting", int'(dmem_req), 1);
        do_reset("midmem");
        check("midmem.dmem_req_off", int'(dmem_req), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
